// File: rtl/top2049_bus_pkg.sv
// Shared types and constants for the TOP2049 microcontroller bus interface.
// Holds the read-FSM encoding, synchronizer depth and register map window.
package top2049_bus_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int OE_ADDR_BIT = 4;

    // Register window served by the programmer core; bus_oe keys off bit 4.
    localparam logic [7:0] REG_10 = 8'h10;
    localparam logic [7:0] REG_11 = 8'h11;
    localparam logic [7:0] REG_12 = 8'h12;
    localparam logic [7:0] REG_13 = 8'h13;
    localparam logic [7:0] REG_14 = 8'h14;
    localparam logic [7:0] REG_15 = 8'h15;
    localparam logic [7:0] REG_16 = 8'h16;
    localparam logic [7:0] REG_17 = 8'h17;
    localparam logic [7:0] REG_18 = 8'h18;
    localparam logic [7:0] REG_19 = 8'h19;
    localparam logic [7:0] REG_1A = 8'h1A;
    localparam logic [7:0] REG_1B = 8'h1B;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_STROBE,
        RD_CAPTURE,
        RD_HOLD
    } rd_state_e;

endpackage

// File: rtl/top2049_bus_if_sync_edge.sv
// Single-bit synchronizer with history flop; flags rising/falling edges of an
// asynchronous pin in the osc domain.
module sync_edge
    import top2049_bus_pkg::*;
#(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic osc,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   level;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: reset loads the idle pin level, not zero, so releasing reset with
    // the pin idle can never look like an edge.
    always_ff @(posedge osc) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            hist_q <= RESET_LEVEL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/top2049_bus_if.sv
// Microcontroller bus front end: synchronizes ale/write/read strobes and data,
// latches address/write data, and runs the read handshake toward the core.
module top2049_bus_if
    import top2049_bus_pkg::*;
(
    input  logic       osc,
    input  logic       rst,
    input  logic       ale,
    input  logic       write,
    input  logic       read,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wstrobe,
    output logic       reg_rstrobe,
    input  logic [7:0] reg_rdata,
    output logic       overlap_err
);

    logic ale_rise, ale_fall, write_rise, write_fall, read_rise, read_fall;
    logic unused_edges;

    sync_edge #(.RESET_LEVEL(1'b1)) u_ale_sync (
        .osc(osc), .rst(rst), .pin(ale), .rise(ale_rise), .fall(ale_fall)
    );
    sync_edge #(.RESET_LEVEL(1'b1)) u_write_sync (
        .osc(osc), .rst(rst), .pin(write), .rise(write_rise), .fall(write_fall)
    );
    sync_edge #(.RESET_LEVEL(1'b1)) u_read_sync (
        .osc(osc), .rst(rst), .pin(read), .rise(read_rise), .fall(read_fall)
    );

    // Edges with no bus meaning; kept so every synchronizer is identical.
    assign unused_edges = ale_rise ^ write_fall;

    logic [SYNC_STAGES-1:0][7:0] din_q, din_d;
    logic [7:0] din_sync;
    logic [7:0] din_dly_q, din_dly_d;
    logic       ale_fall_q, ale_fall_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       wstrobe_q, wstrobe_d;
    logic       overlap_q, overlap_d;
    logic [7:0] bus_dout_q, bus_dout_d;
    logic       rise_pend_q, rise_pend_d;
    rd_state_e  rd_state_q, rd_state_d;

    assign din_sync = din_q[SYNC_STAGES-1];

    // The address commit lags the ale edge by one cycle so a coincident write
    // strobe still shows the address it was aimed at.
    always_comb begin
        din_d       = {din_q[SYNC_STAGES-2:0], bus_din};
        din_dly_d   = din_sync;
        ale_fall_d  = ale_fall;
        reg_addr_d  = ale_fall_q ? din_dly_q : reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        wstrobe_d   = 1'b0;
        overlap_d   = overlap_q | (write_rise & read_fall);
        if (write_rise) begin
            reg_wdata_d = din_sync;
            wstrobe_d   = 1'b1;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rd_state_d  = rd_state_q;
        rise_pend_d = 1'b0;
        bus_dout_d  = bus_dout_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (read_fall && !write_rise) rd_state_d = RD_STROBE;
            end
            RD_STROBE: begin
                rise_pend_d = read_rise;
                rd_state_d  = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                bus_dout_d = reg_rdata;
                rd_state_d = (rise_pend_q || read_rise) ? RD_IDLE : RD_HOLD;
            end
            RD_HOLD: begin
                if (read_rise) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            din_q       <= '0;
            din_dly_q   <= '0;
            ale_fall_q  <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            wstrobe_q   <= 1'b0;
            overlap_q   <= 1'b0;
            bus_dout_q  <= '0;
            rise_pend_q <= 1'b0;
            rd_state_q  <= RD_IDLE;
        end else begin
            din_q       <= din_d;
            din_dly_q   <= din_dly_d;
            ale_fall_q  <= ale_fall_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            wstrobe_q   <= wstrobe_d;
            overlap_q   <= overlap_d;
            bus_dout_q  <= bus_dout_d;
            rise_pend_q <= rise_pend_d;
            rd_state_q  <= rd_state_d;
        end
    end

    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_wstrobe = wstrobe_q;
    assign reg_rstrobe = (rd_state_q == RD_STROBE);
    assign bus_dout    = bus_dout_q;
    assign overlap_err = overlap_q;
    assign bus_oe      = ~read & reg_addr_q[OE_ADDR_BIT];

endmodule
